// File: rtl/cam_frame_gen.sv
// Synthetic 64x64 raster frame source: one frame per accepted START pulse,
// with FRAME_VALID/LINE_VALID framing and four selectable test patterns.
module cam_frame_gen #(
    parameter int WIDTH   = 64,
    parameter int HEIGHT  = 64,
    parameter int PRE_CYC = 4,
    parameter int HBLANK  = 16,
    parameter int DATA_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [1:0]        MODE,
    output logic              FRAME_VALID,
    output logic              LINE_VALID,
    output logic [DATA_W-1:0] DATA,
    output logic [7:0]        X,
    output logic [7:0]        Y,
    output logic              BUSY,
    output logic              FRAME_END,
    output logic [7:0]        FRAME_CNT
);

    localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
    localparam logic [7:0] Y_LAST   = 8'(HEIGHT - 1);
    localparam logic [7:0] PRE_LOAD = 8'(PRE_CYC - 1);
    localparam logic [7:0] HBL_LOAD = 8'(HBLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACTIVE,
        S_HBL,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              fv_q, fv_d;
    logic              lv_q, lv_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              fe_q, fe_d;
    logic [7:0]        pat;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_PRE;
                    mode_d  = MODE;
                    cnt_d   = PRE_LOAD;
                end
            end
            S_PRE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ACTIVE: begin
                if (x_q == X_LAST) begin
                    if (y_q == Y_LAST) begin
                        state_d     = S_DONE;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        state_d = S_HBL;
                        cnt_d   = HBL_LOAD;
                    end
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            S_HBL: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_ACTIVE;
                    x_d     = '0;
                    y_d     = y_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they line up with the state register.
    always_comb begin
        pat = '0;
        case (mode_d)
            2'd0:    pat = {x_d[5:0], 2'b00};
            2'd1:    pat = {y_d[5:0], 2'b00};
            2'd2:    pat = (x_d[3] ^ y_d[3]) ? 8'hFF : 8'h00;
            default: pat = x_d + y_d + frame_cnt_q;
        endcase

        fv_d   = (state_d == S_PRE) || (state_d == S_ACTIVE) || (state_d == S_HBL);
        lv_d   = (state_d == S_ACTIVE);
        busy_d = (state_d != S_IDLE);
        fe_d   = (state_d == S_DONE);
        data_d = lv_d ? DATA_W'(pat) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= '0;
            frame_cnt_q <= '0;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            fv_q        <= fv_d;
            lv_q        <= lv_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            fe_q        <= fe_d;
        end
    end

    assign FRAME_VALID = fv_q;
    assign LINE_VALID  = lv_q;
    assign DATA        = data_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign BUSY        = busy_q;
    assign FRAME_END   = fe_q;
    assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_cam_frame_gen.sv
// Bench for cam_frame_gen: per-cycle output trace compared against an
// arithmetic frame-timing model, plus targeted pixel/timing checks.
module tb_cam_frame_gen;

    localparam int W      = 64;
    localparam int H      = 64;
    localparam int PRE    = 4;
    localparam int HB     = 16;
    localparam int DONE_K = PRE + (H - 1) * (W + HB) + W + 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [1:0] MODE = 2'd0;
    logic       FRAME_VALID, LINE_VALID, BUSY, FRAME_END;
    logic [7:0] DATA, X, Y, FRAME_CNT;

    int n_cmp  = 0;
    int n_fail = 0;

    cam_frame_gen #(
        .WIDTH  (W),
        .HEIGHT (H),
        .PRE_CYC(PRE),
        .HBLANK (HB),
        .DATA_W (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .MODE       (MODE),
        .FRAME_VALID(FRAME_VALID),
        .LINE_VALID (LINE_VALID),
        .DATA       (DATA),
        .X          (X),
        .Y          (Y),
        .BUSY       (BUSY),
        .FRAME_END  (FRAME_END),
        .FRAME_CNT  (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       fv;
        logic       lv;
        logic [7:0] data;
        logic [7:0] x;
        logic [7:0] y;
        logic       busy;
        logic       fe;
        logic [7:0] fcnt;
    } obs_t;

    function automatic obs_t get_obs();
        obs_t o;
        o.fv   = FRAME_VALID;
        o.lv   = LINE_VALID;
        o.data = DATA;
        o.x    = X;
        o.y    = Y;
        o.busy = BUSY;
        o.fe   = FRAME_END;
        o.fcnt = FRAME_CNT;
        return o;
    endfunction

    function automatic logic [7:0] pattern(int m, int x, int y, int fc);
        case (m)
            0:       return 8'((x * 4) % 256);
            1:       return 8'((y * 4) % 256);
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
            default: return 8'((x + y + fc) % 256);
        endcase
    endfunction

    // k = cycles since the edge that accepted START (k >= 1); px/py are X/Y before the frame.
    function automatic obs_t model(int k, int m, int fc, int px, int py);
        obs_t o;
        int   j, xx, yy;
        o      = '0;
        o.fcnt = 8'(fc);
        o.x    = 8'(px);
        o.y    = 8'(py);
        if (k <= PRE) begin
            o.fv   = 1'b1;
            o.busy = 1'b1;
        end else if (k < DONE_K) begin
            j      = k - PRE - 1;
            yy     = j / (W + HB);
            xx     = j % (W + HB);
            o.fv   = 1'b1;
            o.busy = 1'b1;
            o.y    = 8'(yy);
            if (xx < W) begin
                o.lv   = 1'b1;
                o.x    = 8'(xx);
                o.data = pattern(m, xx, yy, fc);
            end else begin
                o.x = 8'(W - 1);
            end
        end else begin
            o.x    = 8'(W - 1);
            o.y    = 8'(H - 1);
            o.fcnt = 8'(fc + 1);
            if (k == DONE_K) begin
                o.busy = 1'b1;
                o.fe   = 1'b1;
            end
        end
        return o;
    endfunction

    function automatic int pix_k(int x, int y);
        return PRE + 1 + y * (W + HB) + x;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST   = 1'b1;
        START = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Caller is at a negedge; returns at the negedge of cycle k=1.
    task automatic pulse_start(input logic [1:0] m);
        START = 1'b1;
        MODE  = m;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        RST   = 1'b1;
        START = 1'b1;
        MODE  = 2'($urandom);
        repeat (3) @(negedge CLK);
        o = get_obs();
        n_cmp++;
        if (o !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL reset_outputs got %h exp %h", o, obs_t'('0));
        end
        RST   = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        o = get_obs();
        n_cmp++;
        if (o !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL reset_idle got %h exp %h", o, obs_t'('0));
        end
    endtask

    task automatic test_mode0_timing();
        obs_t o, e;
        do_reset();
        pulse_start(2'd0);
        for (int k = 1; k <= DONE_K + 1; k++) begin
            o = get_obs();
            e = model(k, 0, 0, 0, 0);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL m0_trace k=%0d got %h exp %h", k, o, e);
            end
            if (k == 5) begin
                n_cmp++;
                if ({LINE_VALID, X, Y, DATA} !== {1'b1, 8'd0, 8'd0, 8'h00}) begin
                    n_fail++;
                    $display("FAIL m0_first_pixel got lv=%0b x=%0d y=%0d d=%h exp lv=1 x=0 y=0 d=00",
                             LINE_VALID, X, Y, DATA);
                end
            end
            if (k == 68) begin
                n_cmp++;
                if ({LINE_VALID, X, DATA} !== {1'b1, 8'd63, 8'hFC}) begin
                    n_fail++;
                    $display("FAIL m0_last_in_line got lv=%0b x=%0d d=%h exp lv=1 x=63 d=fc",
                             LINE_VALID, X, DATA);
                end
            end
            if (k >= 69 && k <= 84) begin
                n_cmp++;
                if (LINE_VALID !== 1'b0 || FRAME_VALID !== 1'b1) begin
                    n_fail++;
                    $display("FAIL m0_hblank k=%0d got lv=%0b fv=%0b exp lv=0 fv=1",
                             k, LINE_VALID, FRAME_VALID);
                end
            end
            if (k == 85) begin
                n_cmp++;
                if ({LINE_VALID, X, Y} !== {1'b1, 8'd0, 8'd1}) begin
                    n_fail++;
                    $display("FAIL m0_line1_start got lv=%0b x=%0d y=%0d exp lv=1 x=0 y=1",
                             LINE_VALID, X, Y);
                end
            end
            if (k <= DONE_K) @(negedge CLK);
        end
    endtask

    task automatic test_full_frame_mode1();
        obs_t o, e;
        int   lv_cnt = 0;
        int   rises  = 0;
        int   fe_k   = -1;
        logic prev_lv = 1'b0;
        do_reset();
        pulse_start(2'd1);
        for (int k = 1; k <= DONE_K + 1; k++) begin
            o = get_obs();
            e = model(k, 1, 0, 0, 0);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL m1_trace k=%0d got %h exp %h", k, o, e);
            end
            if (LINE_VALID === 1'b1) lv_cnt++;
            if (LINE_VALID === 1'b1 && prev_lv === 1'b0) rises++;
            prev_lv = LINE_VALID;
            if (FRAME_END === 1'b1 && fe_k < 0) fe_k = k;
            if (k >= pix_k(0, 63) && k <= pix_k(63, 63)) begin
                n_cmp++;
                if (DATA !== 8'hFC) begin
                    n_fail++;
                    $display("FAIL m1_line63_data k=%0d got %h exp fc", k, DATA);
                end
            end
            MODE = 2'($urandom);
            if (k <= DONE_K) @(negedge CLK);
        end
        n_cmp++;
        if (lv_cnt != W * H) begin
            n_fail++;
            $display("FAIL m1_lv_cycles got %0d exp %0d", lv_cnt, W * H);
        end
        n_cmp++;
        if (rises != H) begin
            n_fail++;
            $display("FAIL m1_lv_rises got %0d exp %0d", rises, H);
        end
        n_cmp++;
        if (fe_k != 5109) begin
            n_fail++;
            $display("FAIL m1_frame_end_time got %0d exp 5109", fe_k);
        end
        n_cmp++;
        if (FRAME_CNT !== 8'd1) begin
            n_fail++;
            $display("FAIL m1_frame_cnt got %0d exp 1", FRAME_CNT);
        end
    endtask

    task automatic test_checker();
        obs_t o, e;
        do_reset();
        pulse_start(2'd2);
        for (int k = 1; k <= DONE_K + 1; k++) begin
            o = get_obs();
            e = model(k, 2, 0, 0, 0);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL m2_trace k=%0d got %h exp %h", k, o, e);
            end
            if (k == pix_k(7, 0)) begin
                n_cmp++;
                if (DATA !== 8'h00) begin
                    n_fail++;
                    $display("FAIL m2_px_7_0 got %h exp 00", DATA);
                end
            end
            if (k == pix_k(8, 0)) begin
                n_cmp++;
                if (DATA !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL m2_px_8_0 got %h exp ff", DATA);
                end
            end
            if (k == pix_k(8, 8)) begin
                n_cmp++;
                if (DATA !== 8'h00) begin
                    n_fail++;
                    $display("FAIL m2_px_8_8 got %h exp 00", DATA);
                end
            end
            if (k <= DONE_K) @(negedge CLK);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        int   px = 0;
        int   py = 0;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            pulse_start(2'd3);
            for (int k = 1; k <= DONE_K + 1; k++) begin
                o = get_obs();
                e = model(k, 3, f, px, py);
                n_cmp++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL b2b_trace f=%0d k=%0d got %h exp %h", f, k, o, e);
                end
                if (k == pix_k(1, 2)) begin
                    n_cmp++;
                    if (DATA !== 8'(3 + f)) begin
                        n_fail++;
                        $display("FAIL b2b_px_1_2 f=%0d got %0d exp %0d", f, DATA, 3 + f);
                    end
                end
                MODE = 2'($urandom);
                if (k <= DONE_K) @(negedge CLK);
            end
            px = W - 1;
            py = H - 1;
        end
        n_cmp++;
        if (FRAME_CNT !== 8'd3) begin
            n_fail++;
            $display("FAIL b2b_frame_cnt got %0d exp 3", FRAME_CNT);
        end
    endtask

    task automatic test_ignored_start();
        obs_t o, e;
        int   m = int'($urandom_range(0, 3));
        int   r = int'($urandom_range(2, DONE_K - 1));
        do_reset();
        pulse_start(2'(m));
        for (int k = 1; k <= DONE_K + 1; k++) begin
            o = get_obs();
            e = model(k, m, 0, 0, 0);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ign_trace k=%0d got %h exp %h", k, o, e);
            end
            START = (k == 100 || k == DONE_K || k == r) && (k <= DONE_K);
            MODE  = 2'($urandom);
            if (k <= DONE_K) @(negedge CLK);
        end
        START = 1'b0;
        for (int i = 2; i <= 20; i++) begin
            @(negedge CLK);
            o = get_obs();
            e = model(DONE_K + i, m, 0, 0, 0);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ign_idle i=%0d got %h exp %h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        obs_t o, e;
        int   m  = int'($urandom_range(0, 3));
        int   m2 = int'($urandom_range(0, 3));
        do_reset();
        pulse_start(2'(m));
        for (int k = 1; k <= 2000; k++) begin
            o = get_obs();
            e = model(k, m, 0, 0, 0);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_pre_trace k=%0d got %h exp %h", k, o, e);
            end
            if (k < 2000) @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        o = get_obs();
        n_cmp++;
        if (o !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got %h exp %h", o, obs_t'('0));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            o = get_obs();
            n_cmp++;
            if (o !== obs_t'('0)) begin
                n_fail++;
                $display("FAIL rst_mid_quiet i=%0d got %h exp %h", i, o, obs_t'('0));
            end
        end
        pulse_start(2'(m2));
        for (int k = 1; k <= DONE_K + 1; k++) begin
            o = get_obs();
            e = model(k, m2, 0, 0, 0);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_post_trace k=%0d got %h exp %h", k, o, e);
            end
            if (k <= DONE_K) @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_timing();
        test_full_frame_mode1();
        test_checker();
        test_back_to_back();
        test_ignored_start();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_frame_gen.md
Name: cam_frame_gen

Overview:
Dummy 64x64 camera frame source for the camera64x64_dummy design. It sits directly downstream of the single-cycle start-pulse generator and consumes its one-clock trigger pulse. Each accepted pulse produces one raster-scanned frame of synthetic pixels with frame/line valid framing. It supplies the downstream capture/FIFO logic in place of a real sensor.

Parameters:
WIDTH, 64, active pixels per line (2..256)
HEIGHT, 64, active lines per frame (1..256)
PRE_CYC, 4, cycles of FRAME_VALID-high lead-in before the first pixel (1..255)
HBLANK, 16, LINE_VALID-low cycles between consecutive lines (1..255)
DATA_W, 8, pixel data width (fixed 8 for pattern definitions)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
START  in  1  single-cycle frame trigger pulse from the pulse generator
MODE  in  2  test-pattern select, sampled when START is accepted
FRAME_VALID  out  1  high from lead-in start through the last pixel
LINE_VALID  out  1  high only while DATA carries an active pixel
DATA  out  8  pixel value, valid when LINE_VALID=1, 0 otherwise
X  out  8  pixel column of current DATA (0..WIDTH-1)
Y  out  8  line index of current DATA (0..HEIGHT-1)
BUSY  out  1  high whenever state is not IDLE
FRAME_END  out  1  one-cycle pulse after the last pixel of a frame
FRAME_CNT  out  8  completed-frame counter, wraps 255->0

Behaviour:
- All outputs registered. Reset (RST=1 at a rising edge): state=IDLE, all outputs 0, FRAME_CNT=0, latched mode=0. Reset mid-frame aborts immediately; no FRAME_END, FRAME_CNT unchanged from 0.
- States: IDLE, PRE, ACTIVE, HBL, DONE.
- IDLE: START=1 at edge T -> latch MODE, PRE at T+1. START in any other state is ignored and not queued.
- PRE: FRAME_VALID=1, LINE_VALID=0, lasts PRE_CYC cycles -> ACTIVE with X=0, Y=0.
- ACTIVE: LINE_VALID=1, X increments 0..WIDTH-1 one per cycle. After X=WIDTH-1: if Y<HEIGHT-1 -> HBL, else -> DONE. No HBLANK after the last line.
- HBL: LINE_VALID=0, FRAME_VALID=1, lasts HBLANK cycles, then ACTIVE with X=0, Y+1.
- DONE: one cycle. FRAME_VALID=0, LINE_VALID=0, FRAME_END=1, FRAME_CNT+1 (mod 256). Next state is IDLE. START in the DONE cycle is ignored. Earliest new START is accepted in the first IDLE cycle.
- X/Y hold their last values outside ACTIVE. DATA=0 when LINE_VALID=0.
- Patterns use latched mode m. fc is FRAME_CNT at frame start. All arithmetic is mod 256.
  - m=0: DATA = X*4 (horizontal ramp)
  - m=1: DATA = Y*4 (vertical ramp)
  - m=2: DATA = (X[3]^Y[3]) ? 8'hFF : 8'h00 (8x8 checker)
  - m=3: DATA = X+Y+fc
- MODE changes during a frame have no effect.
- Default timing, START at cycle T:
  - FRAME_VALID high T+1..T+5108
  - first pixel at T+5
  - last pixel (X=63, Y=63) at T+5108
  - FRAME_END at T+5109
  - BUSY high T+1..T+5109
  - IDLE at T+5110
- General frame length from START to FRAME_END: PRE_CYC + WIDTH*HEIGHT + (HEIGHT-1)*HBLANK + 1 cycles.

Test Plan:
- Reset, then START at T with MODE=0 -> PRE T+1..T+4. First pixel T+5 with X=0, Y=0, DATA=0. Pixel X=63 at T+68 has DATA=8'hFC. LINE_VALID low T+69..T+84. Line 1 starts at T+85.
- Full frame, MODE=1 -> exactly 4096 LINE_VALID cycles, 64 line-valid rising edges. Line 63 DATA=8'hFC. FRAME_END at T+5109, FRAME_CNT=1.
- MODE=2 -> (X=7, Y=0) gives 00; (X=8, Y=0) gives FF; (X=8, Y=8) gives 00.
- MODE=3 over three back-to-back frames, START issued in the first IDLE cycle each time -> pixel (1,2) reads 3, then 4, then 5. FRAME_CNT=3 at the end.
- START pulses at T+100 and in the DONE cycle -> both ignored. Only one frame is produced. Changing MODE mid-frame has no effect on DATA.
- RST asserted at T+2000 -> the next cycle shows all outputs 0 and BUSY=0. No FRAME_END. A subsequent START produces a full, correct frame.
